// File: rtl/mp_coeff_bank_loader_if.sv
// Coefficient stream bundle between the DMA source and the bank loader.
// master drives data/valid/last, slave returns ready.
interface mp_coeff_bank_loader_if;
   logic [31:0] s_data_i;
   logic        s_valid_i;
   logic        s_last_i;
   logic        s_ready_o;

   modport master (
      output s_data_i,
      output s_valid_i,
      output s_last_i,
      input  s_ready_o
   );

   modport slave (
      input  s_data_i,
      input  s_valid_i,
      input  s_last_i,
      output s_ready_o
   );
endinterface

// File: rtl/mp_coeff_bank_loader.sv
// Loads a coefficient stream into the inactive ping-pong LUT bank, then swaps
// the active bank on a frame-boundary strobe once the whole table set is written.
//
// state  | meaning
// IDLE   | no upload in progress, stream not ready
// LOAD   | accepting beats and issuing LUT writes into the inactive bank
// COMMIT | full table set written, waiting for the frame strobe to swap banks
module mp_coeff_bank_loader #(
   parameter int M          = 3,
   parameter int RESOLUTION = 4096,
   parameter int NUM_W      = (M > 0) ? $clog2(M + 1) : 1,
   parameter int ADDR_W     = $clog2(RESOLUTION)
) (
   input  logic                      AXI_clk_i,
   input  logic                      reset_n_i,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic                      swap_strobe_i,
   mp_coeff_bank_loader_if.slave     s_axis,
   output logic [31:0]               coeff_data_o,
   output logic [ADDR_W-1:0]         coeff_addr_o,
   output logic [NUM_W-1:0]          coeff_num_o,
   output logic                      coeff_bank_o,
   output logic                      coeff_en_o,
   output logic                      active_bank_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   localparam logic [ADDR_W-1:0] ENT_MAX = ADDR_W'(RESOLUTION - 1);
   localparam logic [NUM_W-1:0]  LUT_MAX = NUM_W'(M);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_ent;
   logic [NUM_W-1:0]  r_lut;
   logic [31:0]       r_coeff_data;
   logic [ADDR_W-1:0] r_coeff_addr;
   logic [NUM_W-1:0]  r_coeff_num;
   logic              r_coeff_bank;
   logic              r_coeff_en;
   logic              r_active_bank;
   logic              r_done;
   logic              r_err;

   logic              w_ready;
   logic              w_beat;
   logic              w_ent_wrap;
   logic              w_final;

   assign w_ready    = (r_state == S_LOAD);
   assign w_beat     = s_axis.s_valid_i & w_ready;
   assign w_ent_wrap = (r_ent == ENT_MAX);
   assign w_final    = w_ent_wrap & (r_lut == LUT_MAX);

   always_ff @(posedge AXI_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state       <= S_IDLE;
         r_ent         <= '0;
         r_lut         <= '0;
         r_coeff_data  <= '0;
         r_coeff_addr  <= '0;
         r_coeff_num   <= '0;
         r_coeff_bank  <= 1'b0;
         r_coeff_en    <= 1'b0;
         r_active_bank <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_coeff_en <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_ent        <= '0;
                  r_lut        <= '0;
                  r_err        <= 1'b0;
                  r_coeff_bank <= ~r_active_bank;
                  r_state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               // abort outranks a coincident beat: the beat is dropped, not written
               if (abort_i) begin
                  r_state <= S_IDLE;
               end else if (w_beat) begin
                  r_coeff_data <= s_axis.s_data_i;
                  r_coeff_addr <= r_ent;
                  r_coeff_num  <= r_lut;
                  r_coeff_en   <= 1'b1;
                  if (w_final) begin
                     if (s_axis.s_last_i) begin
                        r_state <= S_COMMIT;
                     end else begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end else if (s_axis.s_last_i) begin
                     r_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end else if (w_ent_wrap) begin
                     r_ent <= '0;
                     r_lut <= r_lut + NUM_W'(1);
                  end else begin
                     r_ent <= r_ent + ADDR_W'(1);
                  end
               end
            end
            S_COMMIT: begin
               if (abort_i) begin
                  r_state <= S_IDLE;
               end else if (swap_strobe_i) begin
                  r_active_bank <= ~r_active_bank;
                  r_coeff_bank  <= r_active_bank;
                  r_done        <= 1'b1;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_axis.s_ready_o = w_ready;
   assign coeff_data_o     = r_coeff_data;
   assign coeff_addr_o     = r_coeff_addr;
   assign coeff_num_o      = r_coeff_num;
   assign coeff_bank_o     = r_coeff_bank;
   assign coeff_en_o       = r_coeff_en;
   assign active_bank_o    = r_active_bank;
   assign busy_o           = (r_state == S_LOAD) | (r_state == S_COMMIT);
   assign done_o           = r_done;
   assign err_o            = r_err;

endmodule

// File: tb/tb_mp_coeff_bank_loader.sv
// Directed bench for the coefficient bank loader with M=1, RESOLUTION=8 (16 beats per upload).
module tb_mp_coeff_bank_loader;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        strobe;
   logic [31:0] coeff_data;
   logic [2:0]  coeff_addr;
   logic [0:0]  coeff_num;
   logic        coeff_bank;
   logic        coeff_en;
   logic        active;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   mp_coeff_bank_loader_if bus ();

   mp_coeff_bank_loader #(.M(1), .RESOLUTION(8)) dut (
      .AXI_clk_i     (clk),
      .reset_n_i     (rst_n),
      .start_i       (start),
      .abort_i       (abort),
      .swap_strobe_i (strobe),
      .s_axis        (bus.slave),
      .coeff_data_o  (coeff_data),
      .coeff_addr_o  (coeff_addr),
      .coeff_num_o   (coeff_num),
      .coeff_bank_o  (coeff_bank),
      .coeff_en_o    (coeff_en),
      .active_bank_o (active),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(bus.s_ready_o), 0);
      chk({tag, "_data"},  coeff_data, 0);
      chk({tag, "_addr"},  32'(coeff_addr), 0);
      chk({tag, "_num"},   32'(coeff_num), 0);
      chk({tag, "_bank"},  32'(coeff_bank), 0);
      chk({tag, "_en"},    32'(coeff_en), 0);
      chk({tag, "_act"},   32'(active), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_err"},   32'(err), 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // one handshake beat k of the upload; write must show up right after the edge
   task automatic beat(input logic [31:0] d, input bit last, input int k, input logic bank);
      bus.s_data_i  = d;
      bus.s_valid_i = 1'b1;
      bus.s_last_i  = last;
      step();
      bus.s_valid_i = 1'b0;
      bus.s_last_i  = 1'b0;
      chk("wr_en",   32'(coeff_en), 1);
      chk("wr_addr", 32'(coeff_addr), k % 8);
      chk("wr_num",  32'(coeff_num), k / 8);
      chk("wr_data", coeff_data, d);
      chk("wr_bank", 32'(coeff_bank), 32'(bank));
   endtask

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      strobe        = 1'b0;
      bus.s_data_i  = '0;
      bus.s_valid_i = 1'b0;
      bus.s_last_i  = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();

      // full upload with swap
      pulse_start();
      chk("load_busy",  32'(busy), 1);
      chk("load_ready", 32'(bus.s_ready_o), 1);
      chk("load_bank",  32'(coeff_bank), 1);
      for (int k = 0; k < 16; k++) beat(32'(k), k == 15, k, 1'b1);
      chk("commit_ready", 32'(bus.s_ready_o), 0);
      chk("commit_busy",  32'(busy), 1);
      for (int i = 0; i < 4; i++) step();
      chk("commit_noswap", 32'(active), 0);
      chk("commit_nodone", 32'(done), 0);
      strobe = 1'b1;
      step();
      strobe = 1'b0;
      chk("swap_act",  32'(active), 1);
      chk("swap_done", 32'(done), 1);
      chk("swap_bank", 32'(coeff_bank), 0);
      chk("swap_busy", 32'(busy), 0);
      step();
      chk("done_pulse", 32'(done), 0);

      // strobe outside COMMIT is ignored
      strobe = 1'b1;
      step();
      strobe = 1'b0;
      chk("idle_strobe_act",  32'(active), 1);
      chk("idle_strobe_done", 32'(done), 0);

      // early last on beat 5
      pulse_start();
      for (int k = 0; k < 5; k++) beat(32'hA000_0000 + 32'(k), k == 4, k, 1'b0);
      chk("early_err",   32'(err), 1);
      chk("early_ready", 32'(bus.s_ready_o), 0);
      chk("early_busy",  32'(busy), 0);
      step();
      chk("early_noen",  32'(coeff_en), 0);
      chk("early_act",   32'(active), 1);

      // next start clears err; missing last on the final beat
      pulse_start();
      chk("restart_err", 32'(err), 0);
      for (int k = 0; k < 16; k++) beat(32'hB000_0000 + 32'(k), 1'b0, k, 1'b0);
      chk("miss_err",   32'(err), 1);
      chk("miss_ready", 32'(bus.s_ready_o), 0);
      chk("miss_busy",  32'(busy), 0);
      strobe = 1'b1;
      step();
      strobe = 1'b0;
      chk("miss_act", 32'(active), 1);

      // backpressure gaps, then abort coincident with strobe in COMMIT
      pulse_start();
      for (int k = 0; k < 16; k++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            step();
            chk("gap_noen", 32'(coeff_en), 0);
         end
         beat(32'hC000_0000 + 32'(k), k == 15, k, 1'b0);
      end
      chk("bp_busy", 32'(busy), 1);
      abort  = 1'b1;
      strobe = 1'b1;
      step();
      abort  = 1'b0;
      strobe = 1'b0;
      chk("abort_commit_act",  32'(active), 1);
      chk("abort_commit_done", 32'(done), 0);
      chk("abort_commit_busy", 32'(busy), 0);
      chk("abort_commit_err",  32'(err), 0);

      // abort during LOAD with a valid beat 9
      pulse_start();
      for (int k = 0; k < 8; k++) beat(32'hD000_0000 + 32'(k), 1'b0, k, 1'b0);
      start         = 1'b1;
      bus.s_data_i  = 32'hD000_0008;
      bus.s_valid_i = 1'b1;
      abort         = 1'b1;
      step();
      start         = 1'b0;
      bus.s_valid_i = 1'b0;
      abort         = 1'b0;
      chk("abort_load_en",   32'(coeff_en), 0);
      chk("abort_load_data", coeff_data, 32'hD000_0007);
      chk("abort_load_busy", 32'(busy), 0);
      chk("abort_load_err",  32'(err), 0);
      step();
      chk("abort_load_act",  32'(active), 1);

      // reset mid-LOAD after beat 3
      pulse_start();
      for (int k = 0; k < 3; k++) beat(32'hE000_0000 + 32'(k), 1'b0, k, 1'b0);
      bus.s_valid_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      bus.s_valid_i = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      pulse_start();
      chk("post_rst_bank", 32'(coeff_bank), 1);
      beat(32'hF000_0000, 1'b0, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
